// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the data-side bus arbiter: address map,
// FSM states and slave-select codes.
package mem_bus_arbiter_pkg;

    localparam logic [31:0] DM_END_ADDR   = 32'h0000_2fff;
    localparam logic [31:0] TC1_BASE_ADDR = 32'h0000_7f00;
    localparam logic [31:0] TC2_BASE_ADDR = 32'h0000_7f10;
    localparam logic [31:0] TC_COUNT_OFS  = 32'h0000_0008;
    localparam logic [31:0] TC_LAST_OFS   = 32'h0000_000b;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DM,
        SEL_TC1,
        SEL_TC2
    } slave_sel_e;

endpackage

// File: rtl/mem_bus_arbiter_bus_addr_decode.sv
// Combinational address decode: picks the target slave and flags accesses
// that must be rejected (unmapped, misaligned, illegal timer stores).
module bus_addr_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DM_END   = mem_bus_arbiter_pkg::DM_END_ADDR,
    parameter logic [31:0] TC1_BASE = mem_bus_arbiter_pkg::TC1_BASE_ADDR,
    parameter logic [31:0] TC2_BASE = mem_bus_arbiter_pkg::TC2_BASE_ADDR
) (
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    output slave_sel_e  sel,
    output logic        err
);

    logic        in_tc1;
    logic        in_tc2;
    logic        lanes_ok;
    logic        timer_sel;
    logic [31:0] tc_ofs;

    assign in_tc1 = (addr >= TC1_BASE) && (addr <= TC1_BASE + TC_LAST_OFS);
    assign in_tc2 = (addr >= TC2_BASE) && (addr <= TC2_BASE + TC_LAST_OFS);

    // Loads carry no width information, so lane/alignment checks apply to stores only.
    always_comb begin
        case (byteen)
            4'b1111: lanes_ok = (addr[1:0] == 2'b00);
            4'b0011: lanes_ok = (addr[1:0] == 2'b00);
            4'b1100: lanes_ok = (addr[1:0] == 2'b10);
            4'b0001: lanes_ok = (addr[1:0] == 2'b00);
            4'b0010: lanes_ok = (addr[1:0] == 2'b01);
            4'b0100: lanes_ok = (addr[1:0] == 2'b10);
            4'b1000: lanes_ok = (addr[1:0] == 2'b11);
            default: lanes_ok = 1'b0;
        endcase
    end

    always_comb begin
        sel = SEL_NONE;
        if (addr <= DM_END) begin
            sel = SEL_DM;
        end else if (in_tc1) begin
            sel = SEL_TC1;
        end else if (in_tc2) begin
            sel = SEL_TC2;
        end
    end

    assign timer_sel = (sel == SEL_TC1) || (sel == SEL_TC2);
    assign tc_ofs    = (sel == SEL_TC1) ? (addr - TC1_BASE) : (addr - TC2_BASE);

    always_comb begin
        err = 1'b0;
        if (sel == SEL_NONE) begin
            err = 1'b1;
        end else if (we) begin
            if (!lanes_ok) begin
                err = 1'b1;
            end else if (timer_sel && ((byteen != 4'b1111) || (tc_ofs >= TC_COUNT_OFS))) begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the DM/timer data bus: one outstanding
// transaction, 3-cycle IDLE->ACCESS->RESP handshake, decode errors reported via err.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DM_END   = mem_bus_arbiter_pkg::DM_END_ADDR,
    parameter logic [31:0] TC1_BASE = mem_bus_arbiter_pkg::TC1_BASE_ADDR,
    parameter logic [31:0] TC2_BASE = mem_bus_arbiter_pkg::TC2_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  dm_byteen,
    output logic        tc1_we,
    output logic        tc2_we,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] tc1_rdata,
    input  logic [31:0] tc2_rdata
);

    state_e      state;
    slave_sel_e  sel_q;
    slave_sel_e  dec_sel;
    logic        dec_err;
    logic        last_grant;
    logic        grant;
    logic        lat_we;
    logic        lat_err;
    logic        any_req;
    logic        pick;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic [31:0] slave_rdata;
    logic        rd_ok;

    assign any_req = m0_req || m1_req;
    // Port 1 wins when alone, or when both request and port 0 was served last.
    assign pick       = m1_req && (!m0_req || (last_grant == 1'b0));
    assign req_we     = pick ? m1_we     : m0_we;
    assign req_addr   = pick ? m1_addr   : m0_addr;
    assign req_byteen = pick ? m1_byteen : m0_byteen;
    assign req_wdata  = pick ? m1_wdata  : m0_wdata;

    bus_addr_decode #(
        .DM_END   (DM_END),
        .TC1_BASE (TC1_BASE),
        .TC2_BASE (TC2_BASE)
    ) u_decode (
        .addr   (req_addr),
        .we     (req_we),
        .byteen (req_byteen),
        .sel    (dec_sel),
        .err    (dec_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            sel_q      <= SEL_NONE;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            dm_byteen  <= '0;
            tc1_we     <= 1'b0;
            tc2_we     <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            dm_byteen <= '0;
            tc1_we    <= 1'b0;
            tc2_we    <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        lat_we    <= req_we;
                        lat_err   <= dec_err;
                        sel_q     <= dec_sel;
                        bus_addr  <= req_addr;
                        bus_wdata <= req_wdata;
                        // Strobes are launched here so they are live for the ACCESS cycle only.
                        if (req_we && !dec_err) begin
                            case (dec_sel)
                                SEL_DM:  dm_byteen <= req_byteen;
                                SEL_TC1: tc1_we    <= 1'b1;
                                SEL_TC2: tc2_we    <= 1'b1;
                                default: ;
                            endcase
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    m0_ack <= !grant;
                    m1_ack <= grant;
                    m0_err <= !grant && lat_err;
                    m1_err <= grant && lat_err;
                    state  <= RESP;
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        slave_rdata = '0;
        case (sel_q)
            SEL_DM:  slave_rdata = dm_rdata;
            SEL_TC1: slave_rdata = tc1_rdata;
            SEL_TC2: slave_rdata = tc2_rdata;
            default: slave_rdata = '0;
        endcase
    end

    assign rd_ok    = (state == RESP) && !lat_we && !lat_err;
    assign m0_rdata = (rd_ok && !grant) ? slave_rdata : '0;
    assign m1_rdata = (rd_ok && grant)  ? slave_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small synchronous DM model and
// constant timer read data; expected values are hand-computed.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  dm_byteen;
    logic        tc1_we, tc2_we;
    logic [31:0] dm_rdata = '0;
    logic [31:0] tc1_rdata = 32'hc1c1_0001;
    logic [31:0] tc2_rdata = 32'hc2c2_0002;

    int tests = 0;
    int fails = 0;
    int dm_stb = 0;
    int tc1_stb = 0;
    int tc2_stb = 0;
    logic [8:0] a0_hist, a1_hist;
    logic [31:0] m1_rd_seen;

    logic [31:0] mem [0:15] = '{
        32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
        32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007,
        32'h1000_0008, 32'h1000_0009, 32'h1000_000a, 32'h1000_000b,
        32'h1000_000c, 32'h1000_000d, 32'h1000_000e, 32'h1000_000f};

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_byteen (m0_byteen),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_byteen (m1_byteen),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .m1_rdata  (m1_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .dm_byteen (dm_byteen),
        .tc1_we    (tc1_we),
        .tc2_we    (tc2_we),
        .dm_rdata  (dm_rdata),
        .tc1_rdata (tc1_rdata),
        .tc2_rdata (tc2_rdata)
    );

    // Synchronous DM: lane writes on dm_byteen, read data one cycle after bus_addr.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dm_byteen[b]) mem[bus_addr[5:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
        end
        dm_rdata <= mem[bus_addr[5:2]];
        if (dm_byteen != 4'b0000) dm_stb <= dm_stb + 1;
        if (tc1_we) tc1_stb <= tc1_stb + 1;
        if (tc2_we) tc2_stb <= tc2_stb + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_byteen = be; m0_wdata = wd;
    endtask

    task automatic req1(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_byteen = be; m1_wdata = wd;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_byteen = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_byteen = '0; m1_wdata = '0;
        #2 reset = 1'b0;
        tick();
        check("rst_m0_ack", m0_ack, 0);
        check("rst_m1_ack", m1_ack, 0);
        check("rst_dm_byteen", dm_byteen, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_tc_we", {tc1_we, tc2_we}, 0);
        tick();
        reset = 1'b1;
        tick();

        // m0 word store to DM
        req0(1, 32'h0000_0010, 4'b1111, 32'hdead_beef);
        tick();
        check("st_dm_byteen", dm_byteen, 4'b1111);
        check("st_bus_addr", bus_addr, 32'h0000_0010);
        check("st_bus_wdata", bus_wdata, 32'hdead_beef);
        check("st_early_ack", m0_ack, 0);
        tick();
        check("st_ack", m0_ack, 1);
        check("st_err", m0_err, 0);
        check("st_rdata", m0_rdata, 0);
        check("st_strobe_off", dm_byteen, 0);
        m0_req = 0;
        tick();
        check("st_ack_pulse", m0_ack, 0);

        // m0 load back
        req0(0, 32'h0000_0010, 4'b0000, '0);
        tick();
        check("ld_no_strobe", dm_byteen, 0);
        tick();
        check("ld_ack", m0_ack, 1);
        check("ld_rdata", m0_rdata, 32'hdead_beef);
        m0_req = 0;
        tick();

        // Both ports held from reset: m0 first, then strict alternation
        reset = 1'b0;
        req0(0, 32'h0000_0010, 4'b0000, '0);
        req1(0, 32'h0000_0014, 4'b0000, '0);
        tick();
        reset = 1'b1;
        a0_hist = '0; a1_hist = '0; m1_rd_seen = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            a0_hist[k-1] = m0_ack;
            a1_hist[k-1] = m1_ack;
            if (k == 5) m1_rd_seen = m1_rdata;
        end
        m0_req = 0; m1_req = 0;
        check("rr_m0_acks", {23'd0, a0_hist}, 32'h0000_0082);
        check("rr_m1_acks", {23'd0, a1_hist}, 32'h0000_0010);
        check("rr_m1_rdata", m1_rd_seen, 32'h1000_0005);
        repeat (3) tick();

        // m1 store to TC1 CTRL/PRESET
        req1(1, 32'h0000_7f04, 4'b1111, 32'h0000_0055);
        tick();
        check("tc1_we_on", tc1_we, 1);
        check("tc1_no_dm", dm_byteen, 0);
        tick();
        check("tc1_ack", {m1_ack, m1_err, m0_ack}, 3'b100);
        check("tc1_we_off", tc1_we, 0);
        m1_req = 0;
        tick();

        // m1 store to TC2 COUNT: rejected
        req1(1, 32'h0000_7f18, 4'b1111, 32'h0000_0077);
        tick();
        check("tc2cnt_no_we", tc2_we, 0);
        tick();
        check("tc2cnt_err", {m1_ack, m1_err}, 2'b11);
        m1_req = 0;
        tick();

        // m0 half store to TC2: rejected
        req0(1, 32'h0000_7f10, 4'b0011, 32'h0000_1234);
        tick();
        check("tc2half_no_we", tc2_we, 0);
        tick();
        check("tc2half_err", {m0_ack, m0_err}, 2'b11);
        m0_req = 0;
        tick();

        // m0 load past DM_END: rejected, rdata 0
        req0(0, 32'h0000_3000, 4'b0000, '0);
        repeat (2) tick();
        check("oob_err", {m0_ack, m0_err}, 2'b11);
        check("oob_rdata", m0_rdata, 0);
        m0_req = 0;
        tick();

        // misaligned word store
        req0(1, 32'h0000_0002, 4'b1111, 32'hffff_ffff);
        tick();
        check("mis_no_strobe", dm_byteen, 0);
        tick();
        check("mis_err", {m0_ack, m0_err}, 2'b11);
        m0_req = 0;
        tick();

        // byte store at last DM byte, then word load at DM_END-3
        req0(1, 32'h0000_2fff, 4'b1000, 32'hab00_0000);
        tick();
        check("end_byteen", dm_byteen, 4'b1000);
        tick();
        check("end_ack", {m0_ack, m0_err}, 2'b10);
        m0_req = 0;
        tick();
        req0(0, 32'h0000_2ffc, 4'b0000, '0);
        repeat (2) tick();
        check("end_rdata", m0_rdata, 32'hab00_000f);
        m0_req = 0;
        tick();

        // hole between TC1 and TC2 windows
        req0(0, 32'h0000_7f0c, 4'b0000, '0);
        repeat (2) tick();
        check("hole_err", {m0_ack, m0_err}, 2'b11);
        m0_req = 0;
        tick();

        // timer load from COUNT is legal, full word
        req0(0, 32'h0000_7f14, 4'b0000, '0);
        repeat (2) tick();
        check("tc2_ld_err", m0_err, 0);
        check("tc2_ld_rdata", m0_rdata, 32'hc2c2_0002);
        m0_req = 0;
        tick();

        // reset during ACCESS of an m1 store: aborted, next grant to m0
        req1(1, 32'h0000_0020, 4'b1111, 32'h5555_aaaa);
        tick();
        #1 reset = 1'b0;
        #1;
        check("abort_strobe", dm_byteen, 0);
        tick();
        check("abort_no_ack", {m0_ack, m1_ack}, 0);
        tick();
        check("abort_no_ack2", {m0_ack, m1_ack}, 0);
        req0(0, 32'h0000_0010, 4'b0000, '0);
        req1(0, 32'h0000_0020, 4'b0000, '0);
        reset = 1'b1;
        repeat (2) tick();
        check("post_rst_m0_first", {m0_ack, m1_ack}, 2'b10);
        check("post_rst_rdata", m0_rdata, 32'hdead_beef);
        tick();
        m0_req = 0;
        repeat (2) tick();
        check("post_rst_m1_ack", {m0_ack, m1_ack}, 2'b01);
        check("abort_no_write", m1_rdata, 32'h1000_0008);
        m1_req = 0;
        repeat (3) tick();

        check("dm_strobe_count", dm_stb, 2);
        check("tc1_strobe_count", tc1_stb, 1);
        check("tc2_strobe_count", tc2_stb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
